reg_file: RTL
=============

# reg_file

LC-3b general-purpose register file with condition-code and branch-enable logic. It sits around the ALU. It supplies the ALU's A operand from SR1 and its B operand through SR2MUX (SR2 or sign-extended imm5). It captures the shared 16-bit bus, which the ALU drives when gated, into the destination register and the NZP flags. Writes are synchronous; reads and operand muxing are combinational.

## Interface
Parameters:
- none; word width 16 and register count 8 are architectural.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- bus  in  16  shared datapath bus (ALU output, MDR, PC, etc.); sampled only when a load is asserted
- ir  in  16  current instruction register contents
- ld_reg  in  1  write bus into the DR selected by drmux
- ld_cc  in  1  update N/Z/P from bus
- ld_ben  in  1  update ben from ir[11:9] and current N/Z/P
- drmux  in  1  0: DR = ir[11:9]; 1: DR = 3'd7 (JSR/TRAP link)
- sr1mux  in  1  0: SR1 = ir[11:9]; 1: SR1 = ir[8:6]
- sr1_out  out  16  contents of SR1; feeds ALU A
- sr2mux_out  out  16  ir[5]=0: contents of R[ir[2:0]]; ir[5]=1: sign-extended ir[4:0]; feeds ALU B
- n, z, p  out  1 each  condition codes
- ben  out  1  registered branch enable

## Operation
- Storage: R0–R7, 16 bits each, plus N, Z, P and BEN flops.
- Write: on a rising clk with ld_reg=1, R[DR] <= bus. No other register changes.
- DR selection follows drmux. drmux=1 always writes R7, whatever ir holds.
- Condition codes: on a rising clk with ld_cc=1, the flags are set from bus, treated as two's-complement.
  - bus[15]=1: NZP = 100
  - bus == 16'h0000: NZP = 010
  - otherwise: NZP = 001
  - Exactly one flag is high at all times, including after reset.
- BEN: on a rising clk with ld_ben=1, ben <= (ir[11]&n) | (ir[10]&z) | (ir[9]&p). It uses the flag values held before that edge.
- Reads: sr1_out and sr2mux_out are purely combinational from ir and register contents.
  - sign-extension: {{11{ir[4]}}, ir[4:0]}
- ld_reg, ld_cc and ld_ben are independent. Any combination may be asserted in the same cycle, and each acts on pre-edge state.
- When all loads are low, bus content (including X/Z) has no effect on state.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately with no clock needed):
  - R0–R7 = 16'h0000
  - N/Z/P = 0/1/0
  - ben = 0
  - sr1_out and sr2mux_out settle to the reset register values (or the imm5 extension).
- Reset release: state updates resume on the first rising clk with rst_n=1.
- Reset asserted mid-cycle overrides any pending load; no partial write survives.
- Write latency is 1 cycle: a value written at edge k is visible on the read outputs after edge k.
- Read-during-write to the same register returns the old value before the edge and the new value after it. There is no bypass.
- ld_cc together with ld_reg in the same cycle: flags reflect bus, i.e. the value being written.
- ld_ben together with ld_cc in the same cycle: ben is computed from the old NZP.
- All outputs are driven at all times. This block never tri-states.

## Test plan
- Reset
  - Stimulus: assert rst_n=0 asynchronously between edges, with ld_reg=1 and bus=16'hBEEF.
  - Required: all R read 0000, NZP=010, ben=0; no write occurs.
  - Release rst_n, then with ir[8:6]=3 and sr1mux=1: sr1_out=0000.
- Write/read all registers
  - Stimulus: write R_i = 16'h1111*i for i=0..7 with drmux=0.
  - Required: read each back via SR1 (both sr1mux settings) and via SR2 (ir[5]=0); all match.
  - Then drmux=1, ir[11:9]=2, bus=16'hCAFE: R7=CAFE and R2 unchanged.
- SR2MUX immediate
  - ir[5]=1, ir[4:0]=5'b10000 → sr2mux_out=FFF0.
  - ir[4:0]=5'b01111 → 000F.
  - ir[5]=0, ir[2:0]=4 → contents of R4.
- Condition codes
  - ld_cc with bus=8000 → NZP=100.
  - bus=0000 → 010.
  - bus=7FFF → 001.
  - Then bus=8000 with ld_cc=0 → NZP stays 001.
- Branch enable
  - NZP=010 and ir[11:9]=010, pulse ld_ben → ben=1.
  - ir[11:9]=101 → ben=0.
  - Same cycle ld_cc (bus=FFFF) and ld_ben with ir[11:9]=010 from old NZP=010 → ben=1, NZP=100.
- Read-during-write
  - R3=0005; ld_reg with DR=3, bus=0009, sr1mux=0, ir[11:9]=3.
  - Required: sr1_out=0005 before the edge and 0009 after it.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: LC-3b register file (R0-R7), NZP condition codes and branch enable.
// Writes, flag and BEN updates are synchronous; operand reads and SR2MUX are combinational.
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus,
  input  logic [15:0] ir,
  input  logic        ld_reg,
  input  logic        ld_cc,
  input  logic        ld_ben,
  input  logic        drmux,
  input  logic        sr1mux,
  output logic [15:0] sr1_out,
  output logic [15:0] sr2mux_out,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic        ben
);

  logic [15:0] r_regs [0:7];
  logic        r_n;
  logic        r_z;
  logic        r_p;
  logic        r_ben;

  logic [2:0]  w_dr;
  logic [2:0]  w_sr1;
  logic [15:0] w_imm5;
  logic        w_unused_ir;

  // Opcode bits are decoded elsewhere; this block never looks at them.
  assign w_unused_ir = ^ir[15:12];

  // Destination and source register selection.
  always_comb begin
    w_dr   = drmux  ? 3'd7     : ir[11:9];
    w_sr1  = sr1mux ? ir[8:6]  : ir[11:9];
    w_imm5 = {{11{ir[4]}}, ir[4:0]};
  end

  // Register write: only the selected destination changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (ld_reg) begin
      r_regs[w_dr] <= bus;
    end
  end

  // Condition codes from bus as a two's-complement value; exactly one is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
      r_z <= 1'b1;
      r_p <= 1'b0;
    end else if (ld_cc) begin
      r_n <= bus[15];
      r_z <= (bus == 16'h0000);
      r_p <= ~bus[15] & (bus != 16'h0000);
    end
  end

  // Branch enable uses the flags held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ben <= 1'b0;
    end else if (ld_ben) begin
      r_ben <= (ir[11] & r_n) | (ir[10] & r_z) | (ir[9] & r_p);
    end
  end

  // Combinational operand reads; no write bypass.
  always_comb begin
    sr1_out    = r_regs[w_sr1];
    sr2mux_out = ir[5] ? w_imm5 : r_regs[ir[2:0]];
    n          = r_n;
    z          = r_z;
    p          = r_p;
    ben        = r_ben;
  end

endmodule
